// File: rtl/tt_proj_mux_ctrl.sv
// Purpose: shares one pad interface among N_PROJ project wrappers; owns the project select counter and the guard/reset-hold sequencing on every switch.
// Latency: a control pad edge takes effect 3 clk later; proj_ena/active are registered, proj_iw/pad_ow are combinational from state.
// Backpressure: none; the pads are free-running levels/edges and every wrapper output is simply muxed.
module tt_proj_mux_ctrl #(
    parameter int N_PROJ    = 16,
    parameter int SEL_W     = 4,
    parameter int GUARD_CYC = 4,
    parameter int RST_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_sel_rst,
    input  logic                 ctrl_sel_inc,
    input  logic                 ctrl_ena,
    input  logic [17:0]          pad_iw,
    output logic [23:0]          pad_ow,
    output logic [N_PROJ-1:0]    proj_ena,
    output logic [17:0]          proj_iw,
    input  logic [N_PROJ*24-1:0] proj_ow,
    output logic [SEL_W-1:0]     sel_cur,
    output logic                 active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [8:0]       GUARD_LD = 9'(GUARD_CYC - 1);
    localparam logic [8:0]       HOLD_LD  = 9'(RST_HOLD - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_PROJ - 1);

    // Synchroniser stages for the asynchronous control pads
    logic s_rst_m, s_rst;
    logic s_inc_m, s_inc, s_inc_d;
    logic s_ena_m, s_ena;
    logic inc_pulse;

    state_t             state, state_nxt;
    logic [8:0]         cnt, cnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               sel_change;
    logic [N_PROJ-1:0]  ena_nxt;

    // Two-flop synchronisers plus a delay flop for increment edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rst_m <= 1'b0;
            s_rst   <= 1'b0;
            s_inc_m <= 1'b0;
            s_inc   <= 1'b0;
            s_inc_d <= 1'b0;
            s_ena_m <= 1'b0;
            s_ena   <= 1'b0;
        end else begin
            s_rst_m <= ctrl_sel_rst;
            s_rst   <= s_rst_m;
            s_inc_m <= ctrl_sel_inc;
            s_inc   <= s_inc_m;
            s_inc_d <= s_inc;
            s_ena_m <= ctrl_ena;
            s_ena   <= s_ena_m;
        end
    end

    assign inc_pulse = s_inc & ~s_inc_d;

    // Next select value: clear beats increment; increment wraps at N_PROJ-1
    always_comb begin
        sel_nxt = sel_cur;
        if (s_rst) begin
            sel_nxt = '0;
        end else if (inc_pulse) begin
            sel_nxt = (sel_cur == SEL_MAX) ? '0 : sel_cur + SEL_W'(1);
        end
    end

    // A clear of an already-zero counter is not a change
    assign sel_change = (sel_nxt != sel_cur);

    // Select counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_cur <= '0;
        end else begin
            sel_cur <= sel_nxt;
        end
    end

    // Sequencer: disable beats a select change; guard and hold share one down-counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (s_ena) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LD;
                end
            end
            GUARD: begin
                if (!s_ena) begin
                    state_nxt = IDLE;
                end else if (sel_change) begin
                    cnt_nxt = GUARD_LD;
                end else if (cnt == 9'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 9'd1;
                end
            end
            HOLD: begin
                if (!s_ena) begin
                    state_nxt = IDLE;
                end else if (sel_change) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LD;
                end else if (cnt == 9'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 9'd1;
                end
            end
            RUN: begin
                if (!s_ena) begin
                    state_nxt = IDLE;
                end else if (sel_change) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state and shared counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Enable decode from the upcoming state so the registered enable lines up with state
    always_comb begin
        ena_nxt = '0;
        if (state_nxt == HOLD || state_nxt == RUN) begin
            for (int k = 0; k < N_PROJ; k++) begin
                if (sel_nxt == SEL_W'(k)) begin
                    ena_nxt[k] = 1'b1;
                end
            end
        end
    end

    // Registered enables and run indicator
    always_ff @(posedge clk) begin
        if (rst) begin
            proj_ena <= '0;
            active   <= 1'b0;
        end else begin
            proj_ena <= ena_nxt;
            active   <= (state_nxt == RUN);
        end
    end

    // Input word gating: nothing in IDLE/GUARD, project reset held low during HOLD
    always_comb begin
        proj_iw = '0;
        if (state == HOLD) begin
            proj_iw = pad_iw & ~18'h00002;
        end else if (state == RUN) begin
            proj_iw = pad_iw;
        end
    end

    // Output word steering from the selected wrapper while it is enabled
    always_comb begin
        pad_ow = '0;
        if (state == HOLD || state == RUN) begin
            for (int k = 0; k < N_PROJ; k++) begin
                if (sel_cur == SEL_W'(k)) begin
                    pad_ow = proj_ow[k*24 +: 24];
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Bench for tt_proj_mux_ctrl: vector table for the select counter, directed
// sequences for switch/disable/reset corners, then random pad activity checked
// every cycle against an epoch-age reference model.
module tb_tt_proj_mux_ctrl;

    localparam int N  = 16;
    localparam int SW = 4;
    localparam int G  = 4;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_sel_rst;
    logic          ctrl_sel_inc;
    logic          ctrl_ena;
    logic [17:0]   pad_iw;
    logic [23:0]   pad_ow;
    logic [N-1:0]  proj_ena;
    logic [17:0]   proj_iw;
    logic [N*24-1:0] proj_ow;
    logic [SW-1:0] sel_cur;
    logic          active;

    tt_proj_mux_ctrl #(.N_PROJ(N), .SEL_W(SW), .GUARD_CYC(G), .RST_HOLD(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_sel_rst (ctrl_sel_rst),
        .ctrl_sel_inc (ctrl_sel_inc),
        .ctrl_ena     (ctrl_ena),
        .pad_iw       (pad_iw),
        .pad_ow       (pad_ow),
        .proj_ena     (proj_ena),
        .proj_iw      (proj_iw),
        .proj_ow      (proj_ow),
        .sel_cur      (sel_cur),
        .active       (active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit auto_on = 1'b0;

    // Reference model: pads are seen two samples late; the controller is
    // described by the age of the current enabled epoch (-1 = disabled).
    bit [1:0] ena_sh;
    bit [1:0] rs_sh;
    bit [2:0] inc_sh;
    int       m_sel;
    int       m_since;

    typedef struct {
        logic          rs;
        logic          inc;
        logic [SW-1:0] exp_sel;
        logic [N-1:0]  exp_ena;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        int nsel;
        bit chg;
        if (rst) begin
            ena_sh = '0; rs_sh = '0; inc_sh = '0;
            m_sel = 0; m_since = -1;
        end else begin
            if (rs_sh[1]) nsel = 0;
            else if (inc_sh[1] && !inc_sh[2]) nsel = (m_sel + 1) % N;
            else nsel = m_sel;
            chg = (nsel != m_sel);
            if (!ena_sh[1]) m_since = -1;
            else if (m_since < 0 || chg) m_since = 0;
            else if (m_since < G + H) m_since++;
            m_sel  = nsel;
            ena_sh = {ena_sh[0], ctrl_ena};
            rs_sh  = {rs_sh[0], ctrl_sel_rst};
            inc_sh = {inc_sh[1:0], ctrl_sel_inc};
        end
    endtask

    task automatic auto_chk();
        logic [N-1:0] e_ena;
        logic [17:0]  e_iw;
        logic [23:0]  e_ow;
        logic         e_act;
        e_ena = '0; e_iw = '0; e_ow = '0; e_act = 1'b0;
        if (m_since >= G) begin
            e_ena = N'(1) << m_sel;
            e_ow  = proj_ow[m_sel*24 +: 24];
        end
        if (m_since >= G && m_since < G + H) e_iw = pad_iw & ~18'h00002;
        if (m_since >= G + H) begin
            e_iw  = pad_iw;
            e_act = 1'b1;
        end
        chk("m_ena", 64'(proj_ena), 64'(e_ena));
        chk("m_iw",  64'(proj_iw),  64'(e_iw));
        chk("m_ow",  64'(pad_ow),   64'(e_ow));
        chk("m_act", 64'(active),   64'(e_act));
        chk("m_sel", 64'(sel_cur),  64'(m_sel));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        if (auto_on) auto_chk();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_ow();
        for (int k = 0; k < N; k++) proj_ow[k*24 +: 24] = 24'($urandom);
    endtask

    initial begin
        rst = 1'b1; ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
        pad_iw = '0;
        proj_ow = '0;
        rand_ow();
        m_sel = 0; m_since = -1; ena_sh = '0; rs_sh = '0; inc_sh = '0;

        // Reset state
        ticks(2);
        rst = 1'b0;
        chk("rst_ena", 64'(proj_ena), 64'd0);
        chk("rst_sel", 64'(sel_cur),  64'd0);
        chk("rst_act", 64'(active),   64'd0);
        chk("rst_iw",  64'(proj_iw),  64'd0);
        chk("rst_ow",  64'(pad_ow),   64'd0);
        auto_on = 1'b1;

        // Select counter vector table (enable held low)
        tbl.push_back('{rs: 1'b1, inc: 1'b0, exp_sel: SW'(0), exp_ena: '0});
        for (int i = 1; i <= 16; i++) tbl.push_back('{rs: 1'b0, inc: 1'b1, exp_sel: SW'(i % 16), exp_ena: '0});
        for (int i = 1; i <= 5; i++)  tbl.push_back('{rs: 1'b0, inc: 1'b1, exp_sel: SW'(i), exp_ena: '0});
        tbl.push_back('{rs: 1'b1, inc: 1'b1, exp_sel: SW'(0), exp_ena: '0});
        foreach (tbl[i]) begin
            ctrl_sel_rst = tbl[i].rs;
            ctrl_sel_inc = tbl[i].inc;
            ticks(4);
            ctrl_sel_rst = 1'b0;
            ctrl_sel_inc = 1'b0;
            ticks(4);
            chk("tbl_sel", 64'(sel_cur),  64'(tbl[i].exp_sel));
            chk("tbl_ena", 64'(proj_ena), 64'(tbl[i].exp_ena));
        end

        // Basic enable on project 0: 3 sync + 4 guard, 8 hold, then run
        pad_iw = 18'h3FFFF;
        ctrl_ena = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            chk("en_ena", 64'(proj_ena), (t >= 7) ? 64'd1 : 64'd0);
            chk("en_act", 64'(active),   (t >= 15) ? 64'd1 : 64'd0);
            chk("en_iw1", 64'(proj_iw[1]), (t >= 15) ? 64'd1 : 64'd0);
            if (t >= 15) chk("en_ow", 64'(pad_ow), 64'(proj_ow[23:0]));
        end

        // Switch 0 -> 1 while running
        ctrl_sel_inc = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t == 2) ctrl_sel_inc = 1'b0;
            chk("sw_ena", 64'(proj_ena), (t <= 2) ? 64'd1 : (t <= 6) ? 64'd0 : 64'd2);
            chk("sw_ovl", 64'(proj_ena[0] & proj_ena[1]), 64'd0);
            chk("sw_act", 64'(active), (t <= 2 || t >= 15) ? 64'd1 : 64'd0);
            if (t >= 7 && t <= 14) chk("sw_iw1", 64'(proj_iw[1]), 64'd0);
        end

        // Simultaneous clear and increment while running on project 1
        ctrl_sel_rst = 1'b1;
        ctrl_sel_inc = 1'b1;
        ticks(3);
        chk("si_sel", 64'(sel_cur),  64'd0);
        chk("si_ena", 64'(proj_ena), 64'd0);
        chk("si_act", 64'(active),   64'd0);
        ctrl_sel_rst = 1'b0;
        ctrl_sel_inc = 1'b0;
        ticks(14);

        // Disable while HOLD counter is at 3
        ctrl_ena = 1'b0;
        ticks(4);
        ctrl_ena = 1'b1;
        ticks(11);
        chk("dh_pre", 64'(proj_ena), 64'd1);
        ctrl_ena = 1'b0;
        ticks(2);
        chk("dh_mid", 64'(proj_ena), 64'd1);
        tick();
        chk("dh_ena", 64'(proj_ena), 64'd0);
        chk("dh_iw",  64'(proj_iw),  64'd0);
        chk("dh_ow",  64'(pad_ow),   64'd0);

        // Synchronous reset while running on project 2
        for (int i = 0; i < 2; i++) begin
            ctrl_sel_inc = 1'b1; ticks(4);
            ctrl_sel_inc = 1'b0; ticks(4);
        end
        ctrl_ena = 1'b1;
        ticks(15);
        chk("rr_pre", 64'(proj_ena), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_ena", 64'(proj_ena), 64'd0);
        chk("rr_sel", 64'(sel_cur),  64'd0);
        chk("rr_act", 64'(active),   64'd0);
        ticks(6);
        chk("rr_g", 64'(proj_ena), 64'd0);
        tick();
        chk("rr_h", 64'(proj_ena), 64'd1);
        ticks(7);
        chk("rr_h2", 64'(active), 64'd0);
        tick();
        chk("rr_run", 64'(active), 64'd1);

        // Random pad activity against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) ctrl_ena = ~ctrl_ena;
            if ($urandom_range(0, 24) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
            ctrl_sel_rst = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 499) == 0);
            pad_iw = 18'($urandom);
            rand_ow();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
